mac_dot_ctrl: RTL and testbench

Sequencer that computes unsigned 16x16 dot products on the team's 5-stage `mac` pipeline. It accepts a vector length and a stream of operand pairs, and issues up to one pair per cycle into the `mac`. Accumulator feedback runs through two interleaved partial sums, which the block combines into a 32-bit result. It sits between the operand-fetch logic and a single `mac` instance.

---
 rtl/mac_ctrl_pkg.sv | 29 ++
 rtl/mac_tag_pipe.sv | 37 +++
 rtl/mac_dot_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mac_dot_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg
// Shared types and constants for the dot-product sequencer that drives the
// 5-stage mac pipeline.
//   state_e        : sequencer FSM states
//   MAC_DEPTH      : mac latency in cycles, from issue to acc_out valid
//   MAC_ACC_STAGE  : stage at which the mac samples acc_in
//   MAC_W / ACC_W  : operand and accumulator widths
//   wrap_add       : modulo-2^ACC_W addition helper
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MAC_DEPTH     = 5;
  localparam int MAC_ACC_STAGE = 3;
  localparam int MAC_W         = 16;
  localparam int ACC_W         = 32;

  // Accumulator addition; the carry out is deliberately dropped.
  function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// mac_tag_pipe
// Shift register of {valid, lane} tags that mirrors the mac pipeline, so the
// sequencer knows which partial sum each in-flight product belongs to.
//   clk, rst    : clock, synchronous active-high reset (empties the pipe)
//   in_valid_i  : tag entering stage 1 is valid (pair issued this cycle)
//   in_lane_i   : lane of the issued pair
//   valid_o[i]  : valid bit of stage i+1
//   lane_o[i]   : lane bit of stage i+1
module mac_tag_pipe #(
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             in_lane_i,
  output logic [DEPTH-1:0] valid_o,
  output logic [DEPTH-1:0] lane_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] lane_q;

  // Advance every cycle; bit 0 is stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lane_q  <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], in_valid_i};
      lane_q  <= {lane_q[DEPTH-2:0], in_lane_i};
    end
  end

  assign valid_o = valid_q;
  assign lane_o  = lane_q;

endmodule

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl
// Sequences an unsigned 16x16 dot product through a single 5-stage mac.
// Elements alternate between two partial sums (lanes) so that same-lane
// issues are at least two cycles apart; the final result is p0+p1.
//   clk, rst              : clock, synchronous active-high reset (shared with mac)
//   start, len            : begin an operation of len elements (IDLE only)
//   elem_valid/elem_ready : operand-pair handshake, elem_a/elem_b operands
//   mac_a, mac_b          : operands to the mac (0 = bubble)
//   mac_acc_in            : accumulator input to the mac
//   mac_acc_out           : accumulator output from the mac
//   busy                  : operation in progress
//   done                  : one-cycle pulse, result valid in the same cycle
//   result                : dot product mod 2^32, held until the next done
module mac_dot_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             elem_valid,
  output logic             elem_ready,
  input  logic [MAC_W-1:0] elem_a,
  input  logic [MAC_W-1:0] elem_b,
  output logic [MAC_W-1:0] mac_a,
  output logic [MAC_W-1:0] mac_b,
  output logic [ACC_W-1:0] mac_acc_in,
  input  logic [ACC_W-1:0] mac_acc_out,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ACC_W-1:0]     result_q, result_d;
  logic [ACC_W-1:0]     partial_q [2];
  logic [ACC_W-1:0]     partial_d [2];

  logic                 accept_s;
  logic [MAC_DEPTH-1:0] tag_valid_s;
  logic [MAC_DEPTH-1:0] tag_lane_s;
  logic                 acc_lane_s;
  logic                 out_lane_s;
  logic                 tag_lane_unused;

  assign accept_s = (state_q == RUN) && elem_valid;

  mac_tag_pipe #(
    .DEPTH(MAC_DEPTH)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (accept_s),
    .in_lane_i  (cnt_q[0]),
    .valid_o    (tag_valid_s),
    .lane_o     (tag_lane_s)
  );

  // Only the acc_in stage and the output stage lanes are consumed here.
  assign acc_lane_s      = tag_lane_s[MAC_ACC_STAGE-1];
  assign out_lane_s      = tag_lane_s[MAC_DEPTH-1];
  assign tag_lane_unused = ^tag_lane_s;

  // Issue: operands pass straight through on accept, otherwise a zero bubble.
  assign mac_a = accept_s ? elem_a : {MAC_W{1'b0}};
  assign mac_b = accept_s ? elem_b : {MAC_W{1'b0}};

  // Accumulator feed for the product sitting at the acc_in stage.
  always_comb begin
    mac_acc_in = '0;
    if (!tag_valid_s[MAC_ACC_STAGE-1]) begin
      mac_acc_in = '0;
    end else if (tag_valid_s[MAC_DEPTH-1] && (out_lane_s == acc_lane_s)) begin
      // Same lane issued two cycles earlier: its sum is on acc_out right now
      // and has not reached the partial register yet.
      mac_acc_in = mac_acc_out;
    end else begin
      mac_acc_in = partial_q[acc_lane_s];
    end
  end

  // Next-state, counter, partial capture and result logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    result_d     = result_q;
    partial_d[0] = partial_q[0];
    partial_d[1] = partial_q[1];

    if (tag_valid_s[MAC_DEPTH-1]) begin
      partial_d[out_lane_s] = mac_acc_out;
    end else begin
      partial_d[out_lane_s] = partial_q[out_lane_s];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d        = len;
          cnt_d        = '0;
          partial_d[0] = '0;
          partial_d[1] = '0;
          if (len == '0) begin
            result_d = '0;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == (len_q - LEN_W'(1))) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // Partials are final once no product is left in flight.
        if (tag_valid_s == '0) begin
          result_d = wrap_add(partial_q[0], partial_q[1]);
          state_d  = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      result_q     <= '0;
      partial_q[0] <= '0;
      partial_q[1] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      result_q     <= result_d;
      partial_q[0] <= partial_d[0];
      partial_q[1] <= partial_d[1];
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign elem_ready = (state_q == RUN);
  assign result     = result_q;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Self-checking bench for mac_dot_ctrl with a behavioural 5-stage mac model.
module tb_mac_dot_ctrl;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             elem_valid;
  logic             elem_ready;
  logic [15:0]      elem_a, elem_b, mac_a, mac_b;
  logic [31:0]      mac_acc_in, mac_acc_out, result;
  logic             busy, done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  logic [15:0] va [0:7];
  logic [15:0] vb [0:7];
  logic        vpat [0:7];
  int          vpat_len;

  always #5 clk = ~clk;

  mac_dot_ctrl #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_a      (elem_a),
    .elem_b      (elem_b),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_acc_in  (mac_acc_in),
    .mac_acc_out (mac_acc_out),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // mac model: sample at end of T, add acc_in at end of T+3, acc_out in T+5.
  logic [31:0] m1, m2, m3, m4, m5;
  always_ff @(posedge clk) begin
    if (rst) begin
      m1 <= '0; m2 <= '0; m3 <= '0; m4 <= '0; m5 <= '0;
    end else begin
      m1 <= {16'd0, mac_a} * {16'd0, mac_b};
      m2 <= m1;
      m3 <= m2;
      m4 <= m3 + mac_acc_in;
      m5 <= m4;
    end
  end
  assign mac_acc_out = m5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for done after the last accept; pop and compare the expected result.
  task automatic wait_done(input int n_start, input bit check_lat);
    int n;
    logic [31:0] e;
    n = n_start;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (check_lat) chk("done_latency", n, 32'd7);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("result", result, e);
    end
    @(negedge clk);
    chk("done_pulse_1cyc", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Run one dot product of length L using va/vb and the valid pattern vpat.
  task automatic run_dot(input int L, input bit poke_start);
    logic [31:0] acc;
    int idx, p, n;
    acc = 32'd0;
    for (int i = 0; i < L; i++) acc += {16'd0, va[i]} * {16'd0, vb[i]};
    exp_q.push_back(acc);
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(L);
    @(negedge clk);
    start = 1'b0;
    idx = 0; p = 0; n = 0;
    while (idx < L && n < 200) begin
      elem_valid = vpat[p % vpat_len];
      elem_a     = va[idx];
      elem_b     = vb[idx];
      if (poke_start && idx == 1) begin
        start = 1'b1;
        len   = '0;
      end else begin
        start = 1'b0;
      end
      #1;
      chk("ready_in_run", {31'd0, elem_ready}, 32'd1);
      chk("mac_a_issue", {16'd0, mac_a}, elem_valid ? {16'd0, va[idx]} : 32'd0);
      chk("mac_b_issue", {16'd0, mac_b}, elem_valid ? {16'd0, vb[idx]} : 32'd0);
      @(negedge clk);
      if (elem_valid) idx++;
      p++; n++;
    end
    chk("feed_finished", (idx == L) ? 32'd1 : 32'd0, 32'd1);
    elem_valid = 1'b0;
    start      = 1'b0;
    elem_a     = '0;
    elem_b     = '0;
    chk("busy_in_drain", {31'd0, busy}, 32'd1);
    wait_done(1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; elem_valid = 1'b0; elem_a = '0; elem_b = '0;
    for (int i = 0; i < 8; i++) begin va[i] = '0; vb[i] = '0; vpat[i] = 1'b1; end
    vpat_len = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, elem_ready}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_mac_a", {16'd0, mac_a}, 32'd0);
    chk("rst_mac_b", {16'd0, mac_b}, 32'd0);
    chk("rst_acc_in", mac_acc_in, 32'd0);

    // len=4, back-to-back: forwarding path, result 70.
    va[0] = 16'd1; va[1] = 16'd2; va[2] = 16'd3; va[3] = 16'd4;
    vb[0] = 16'd5; vb[1] = 16'd6; vb[2] = 16'd7; vb[3] = 16'd8;
    run_dot(4, 1'b0);

    // len=0: done the cycle after start, result cleared.
    exp_q.push_back(32'd0);
    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, 1'b0);

    // len=1 max operands.
    va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
    run_dot(1, 1'b0);

    // len=3 with valid gaps 1,0,0,1,0,1 -> 90.
    va[0] = 16'd2; va[1] = 16'd3; va[2] = 16'd4;
    vb[0] = 16'd10; vb[1] = 16'd10; vb[2] = 16'd10;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0;
    vpat[3] = 1'b1; vpat[4] = 1'b0; vpat[5] = 1'b1;
    vpat_len = 6;
    run_dot(3, 1'b0);
    for (int i = 0; i < 8; i++) vpat[i] = 1'b1;
    vpat_len = 1;

    // len=3 all 0xFFFF: wraps; also a len=0 start while busy must be ignored.
    for (int i = 0; i < 3; i++) begin va[i] = 16'hFFFF; vb[i] = 16'hFFFF; end
    run_dot(3, 1'b1);

    // Abort a len=4 run after 2 accepts.
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    elem_valid = 1'b1; elem_a = 16'd1; elem_b = 16'd5;
    @(negedge clk);
    elem_a = 16'd2; elem_b = 16'd6;
    @(negedge clk);
    elem_a = 16'd3; elem_b = 16'd7;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_mac_a", {16'd0, mac_a}, 32'd0);
    rst = 1'b0;
    elem_valid = 1'b0; elem_a = '0; elem_b = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end

    // len=2 after abort: no stale partials.
    va[0] = 16'd1; va[1] = 16'd1; vb[0] = 16'd1; vb[1] = 16'd1;
    run_dot(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
